// File: rtl/l1_assoc_array.sv
// N-way set-associative L1 tag/state/data array with independent controller and snoop ports.
// Lookups are registered (1-cycle latency); victim selection uses invalid-first then tree PLRU.
module l1_assoc_array #(
    parameter int unsigned NUM_SETS   = 64,
    parameter int unsigned NUM_WAYS   = 4,
    parameter int unsigned TAG_BITS   = 20,
    parameter int unsigned LINE_BITS  = 512,
    parameter int unsigned STATE_BITS = 2,
    parameter int unsigned IDX_BITS   = $clog2(NUM_SETS),
    parameter int unsigned WAY_BITS   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    // Controller lookup
    input  logic                  ctrl_rd_valid_i,
    input  logic [IDX_BITS-1:0]   ctrl_rd_index_i,
    input  logic [TAG_BITS-1:0]   ctrl_rd_tag_i,
    output logic                  ctrl_resp_valid_o,
    output logic                  ctrl_hit_o,
    output logic [WAY_BITS-1:0]   ctrl_hit_way_o,
    output logic [STATE_BITS-1:0] ctrl_state_o,
    output logic [LINE_BITS-1:0]  ctrl_line_o,
    output logic [WAY_BITS-1:0]   ctrl_victim_way_o,
    // Controller full-entry write
    input  logic                  ctrl_wr_valid_i,
    input  logic [IDX_BITS-1:0]   ctrl_wr_index_i,
    input  logic [WAY_BITS-1:0]   ctrl_wr_way_i,
    input  logic [TAG_BITS-1:0]   ctrl_wr_tag_i,
    input  logic [STATE_BITS-1:0] ctrl_wr_state_i,
    input  logic [LINE_BITS-1:0]  ctrl_wr_line_i,
    // Snoop lookup
    input  logic                  snoop_rd_valid_i,
    input  logic [IDX_BITS-1:0]   snoop_rd_index_i,
    input  logic [TAG_BITS-1:0]   snoop_rd_tag_i,
    output logic                  snoop_resp_valid_o,
    output logic                  snoop_hit_o,
    output logic [WAY_BITS-1:0]   snoop_hit_way_o,
    output logic [STATE_BITS-1:0] snoop_state_o,
    output logic [LINE_BITS-1:0]  snoop_line_o,
    // Snoop state-only update
    input  logic                  snoop_wr_valid_i,
    input  logic [IDX_BITS-1:0]   snoop_wr_index_i,
    input  logic [WAY_BITS-1:0]   snoop_wr_way_i,
    input  logic [STATE_BITS-1:0] snoop_wr_state_i
);

    localparam int unsigned WaysAlloc = 1 << WAY_BITS;
    localparam int unsigned PlruBits  = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;

    logic [TAG_BITS-1:0]   tag_q  [NUM_SETS][WaysAlloc];
    logic [STATE_BITS-1:0] st_q   [NUM_SETS][WaysAlloc];
    logic [LINE_BITS-1:0]  line_q [NUM_SETS][WaysAlloc];
    logic [PlruBits-1:0]   plru_q [NUM_SETS];

    // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right).
    function automatic logic [PlruBits-1:0] plru_touch(input logic [PlruBits-1:0] bits,
                                                       input logic [WAY_BITS-1:0] way);
        logic [PlruBits-1:0] nb;
        int unsigned         node;
        logic                dir;
        nb   = bits;
        node = 0;
        for (int unsigned l = 0; l < WAY_BITS; l++) begin
            dir = way[WAY_BITS-1-l];
            for (int unsigned n = 0; n < PlruBits; n++) begin
                if (n == node) nb[n] = ~dir;
            end
            node = 2 * node + 1 + 32'(dir);
        end
        return nb;
    endfunction

    function automatic logic [WAY_BITS-1:0] plru_victim(input logic [PlruBits-1:0] bits);
        logic [WAY_BITS-1:0] way;
        int unsigned         node;
        logic                dir;
        way  = '0;
        node = 0;
        for (int unsigned l = 0; l < WAY_BITS; l++) begin
            dir = 1'b0;
            for (int unsigned n = 0; n < PlruBits; n++) begin
                if (n == node) dir = bits[n];
            end
            way[WAY_BITS-1-l] = dir;
            node = 2 * node + 1 + 32'(dir);
        end
        return way;
    endfunction

    logic ctrl_wr_en, snoop_wr_en;
    assign ctrl_wr_en  = ctrl_wr_valid_i && (32'(ctrl_wr_way_i) < NUM_WAYS);
    assign snoop_wr_en = snoop_wr_valid_i && (32'(snoop_wr_way_i) < NUM_WAYS);

    // Controller sees the same-cycle snoop state update of its set.
    logic [STATE_BITS-1:0] ctrl_view_st [NUM_WAYS];
    always_comb begin
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            ctrl_view_st[w] = st_q[ctrl_rd_index_i][w];
            if (snoop_wr_en && (snoop_wr_index_i == ctrl_rd_index_i) &&
                (32'(snoop_wr_way_i) == w)) begin
                ctrl_view_st[w] = snoop_wr_state_i;
            end
        end
    end

    logic                  ctrl_resp_valid_q, ctrl_hit_q, ctrl_hit_d;
    logic [WAY_BITS-1:0]   ctrl_way_q, ctrl_way_d, ctrl_victim_q, ctrl_victim_d;
    logic [STATE_BITS-1:0] ctrl_st_q, ctrl_st_d;
    logic [LINE_BITS-1:0]  ctrl_line_q, ctrl_line_d;
    logic                  inv_found;
    logic [WAY_BITS-1:0]   inv_way;

    always_comb begin
        ctrl_hit_d    = 1'b0;
        ctrl_way_d    = '0;
        ctrl_st_d     = '0;
        ctrl_line_d   = '0;
        ctrl_victim_d = '0;
        inv_found     = 1'b0;
        inv_way       = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (!ctrl_hit_d && (ctrl_view_st[w] != '0) &&
                (tag_q[ctrl_rd_index_i][w] == ctrl_rd_tag_i)) begin
                ctrl_hit_d  = 1'b1;
                ctrl_way_d  = WAY_BITS'(w);
                ctrl_st_d   = ctrl_view_st[w];
                ctrl_line_d = line_q[ctrl_rd_index_i][w];
            end
            if (!inv_found && (ctrl_view_st[w] == '0)) begin
                inv_found = 1'b1;
                inv_way   = WAY_BITS'(w);
            end
        end
        if (inv_found) begin
            ctrl_victim_d = inv_way;
        end else if (NUM_WAYS > 1) begin
            ctrl_victim_d = plru_victim(plru_q[ctrl_rd_index_i]);
        end
        if (!ctrl_rd_valid_i) begin
            ctrl_hit_d    = 1'b0;
            ctrl_way_d    = '0;
            ctrl_st_d     = '0;
            ctrl_line_d   = '0;
            ctrl_victim_d = '0;
        end
    end

    // Snoop lookup observes the array before any same-cycle write.
    logic                  snoop_resp_valid_q, snoop_hit_q, snoop_hit_d;
    logic [WAY_BITS-1:0]   snoop_way_q, snoop_way_d;
    logic [STATE_BITS-1:0] snoop_st_q, snoop_st_d;
    logic [LINE_BITS-1:0]  snoop_line_q, snoop_line_d;

    always_comb begin
        snoop_hit_d  = 1'b0;
        snoop_way_d  = '0;
        snoop_st_d   = '0;
        snoop_line_d = '0;
        if (snoop_rd_valid_i) begin
            for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                if (!snoop_hit_d && (st_q[snoop_rd_index_i][w] != '0) &&
                    (tag_q[snoop_rd_index_i][w] == snoop_rd_tag_i)) begin
                    snoop_hit_d  = 1'b1;
                    snoop_way_d  = WAY_BITS'(w);
                    snoop_st_d   = st_q[snoop_rd_index_i][w];
                    snoop_line_d = line_q[snoop_rd_index_i][w];
                end
            end
        end
    end

    logic [PlruBits-1:0] plru_hit_upd, plru_wr_upd;
    assign plru_hit_upd = plru_touch(plru_q[ctrl_rd_index_i], ctrl_way_d);
    assign plru_wr_upd  = plru_touch(plru_q[ctrl_wr_index_i], ctrl_wr_way_i);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                for (int unsigned w = 0; w < WaysAlloc; w++) begin
                    tag_q[s][w]  <= '0;
                    st_q[s][w]   <= '0;
                    line_q[s][w] <= '0;
                end
                plru_q[s] <= '0;
            end
        end else begin
            if (snoop_wr_en) st_q[snoop_wr_index_i][snoop_wr_way_i] <= snoop_wr_state_i;
            if (ctrl_wr_en) begin
                tag_q[ctrl_wr_index_i][ctrl_wr_way_i]  <= ctrl_wr_tag_i;
                st_q[ctrl_wr_index_i][ctrl_wr_way_i]   <= ctrl_wr_state_i;
                line_q[ctrl_wr_index_i][ctrl_wr_way_i] <= ctrl_wr_line_i;
            end
            // Later assignment wins when the write and the hit target the same set.
            if (ctrl_hit_d) plru_q[ctrl_rd_index_i] <= plru_hit_upd;
            if (ctrl_wr_en) plru_q[ctrl_wr_index_i] <= plru_wr_upd;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_resp_valid_q  <= 1'b0;
            ctrl_hit_q         <= 1'b0;
            ctrl_way_q         <= '0;
            ctrl_st_q          <= '0;
            ctrl_line_q        <= '0;
            ctrl_victim_q      <= '0;
            snoop_resp_valid_q <= 1'b0;
            snoop_hit_q        <= 1'b0;
            snoop_way_q        <= '0;
            snoop_st_q         <= '0;
            snoop_line_q       <= '0;
        end else begin
            ctrl_resp_valid_q  <= ctrl_rd_valid_i;
            ctrl_hit_q         <= ctrl_hit_d;
            ctrl_way_q         <= ctrl_way_d;
            ctrl_st_q          <= ctrl_st_d;
            ctrl_line_q        <= ctrl_line_d;
            ctrl_victim_q      <= ctrl_victim_d;
            snoop_resp_valid_q <= snoop_rd_valid_i;
            snoop_hit_q        <= snoop_hit_d;
            snoop_way_q        <= snoop_way_d;
            snoop_st_q         <= snoop_st_d;
            snoop_line_q       <= snoop_line_d;
        end
    end

    assign ctrl_resp_valid_o  = ctrl_resp_valid_q;
    assign ctrl_hit_o         = ctrl_hit_q;
    assign ctrl_hit_way_o     = ctrl_way_q;
    assign ctrl_state_o       = ctrl_st_q;
    assign ctrl_line_o        = ctrl_line_q;
    assign ctrl_victim_way_o  = ctrl_victim_q;
    assign snoop_resp_valid_o = snoop_resp_valid_q;
    assign snoop_hit_o        = snoop_hit_q;
    assign snoop_hit_way_o    = snoop_way_q;
    assign snoop_state_o      = snoop_st_q;
    assign snoop_line_o       = snoop_line_q;

endmodule
